oc_bus_arbiter: RTL and testbench



---
 rtl/oc_arb_pkg.sv | 18 +
 rtl/oc_arb_rr_pick.sv | 40 ++++
 rtl/oc_bus_arbiter.sv | 131 +++++++++++++
 tb/tb_oc_bus_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/oc_arb_pkg.sv
// oc_arb_pkg: FSM state encodings and the width helper shared by the oc_bus_arbiter files
package oc_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_TURN  = 2'b10
    } st_t;

    // Index width for n requesters, never below one bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/oc_arb_rr_pick.sv
// oc_arb_rr_pick: combinational round-robin picker
//   elig   - eligible request mask (req & ~lockout)
//   ptr    - index of the previous winner; the search starts at (ptr+1) mod N
//   valid  - any eligible request present
//   idx    - winner index
//   onehot - winner one-hot
module oc_arb_rr_pick
    import oc_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]        elig,
    input  logic [clog2(N)-1:0] ptr,
    output logic                valid,
    output logic [clog2(N)-1:0] idx,
    output logic [N-1:0]        onehot
);

    localparam int W = clog2(N);

    logic [W:0] s;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        s     = '0;
        // Walk offsets farthest-first so the requester nearest after ptr is written last and wins;
        // the wrap is mod N, not mod 2^W.
        for (int i = N; i >= 1; i--) begin
            s = {1'b0, ptr} + (W+1)'(i);
            s = (s >= (W+1)'(N)) ? s - (W+1)'(N) : s;
            if (elig[s[W-1:0]]) begin
                valid = 1'b1;
                idx   = s[W-1:0];
            end
        end
        onehot = valid ? N'(1) << idx : '0;
    end

endmodule

// File: rtl/oc_bus_arbiter.sv
// oc_bus_arbiter: round-robin owner arbiter for a wired-AND open-collector bus line
//   clk    - clock, rising edge
//   clr_n  - asynchronous active-low reset
//   req    - level request per requester, held for the whole ownership
//   bus_n  - sampled wired-AND line level (low = pulled down)
//   gnt    - registered one-hot grant
//   oe_n   - active-low driver enables, always ~gnt
//   owner  - index of the current or last grantee
//   tout   - one-cycle pulse on forced release
//   fault  - sticky flag: line seen low while nobody owns it
// Define OCARB_TIMEOUT_EN to cap a grant at HOLD_MAX cycles and lock out the offender until
// it drops req; without it a grant lasts as long as req is held and tout stays 0.
module oc_bus_arbiter
    import oc_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int TURN_CYC = 1,
    parameter int HOLD_MAX = 15
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic [N-1:0]        req,
    input  logic                bus_n,
    output logic [N-1:0]        gnt,
    output logic [N-1:0]        oe_n,
    output logic [clog2(N)-1:0] owner,
    output logic                tout,
    output logic                fault
);

    localparam int W = clog2(N);

    if (N < 2 || N > 8 || TURN_CYC < 1 || TURN_CYC > 15 || HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_param
        $error("oc_bus_arbiter: parameter out of range");
    end

    st_t          state, n_state;
    logic [N-1:0] n_gnt, lockout, elig, p_oh;
    logic [W-1:0] ptr, n_ptr, n_owner, p_idx;
    logic [3:0]   cnt, n_cnt;
    logic         p_valid, grab, drop, hold_exp, n_fault;

    assign elig = req & ~lockout;

    oc_arb_rr_pick #(.N(N)) u_pick (
        .elig   (elig),
        .ptr    (ptr),
        .valid  (p_valid),
        .idx    (p_idx),
        .onehot (p_oh)
    );

    // A new grant is taken from IDLE or at the end of the dead time.
    assign grab = p_valid && (state == ST_IDLE || (state == ST_TURN && cnt == 4'd0));
    assign drop = state == ST_GRANT && (!req[owner] || hold_exp);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= ST_IDLE;
            gnt   <= '0;
            owner <= '0;
            ptr   <= W'(N - 1);
            cnt   <= '0;
            fault <= 1'b0;
        end else begin
            state <= n_state;
            gnt   <= n_gnt;
            owner <= n_owner;
            ptr   <= n_ptr;
            cnt   <= n_cnt;
            fault <= n_fault;
        end
    end

    always_comb begin
        n_state = state;
        n_gnt   = gnt;
        n_owner = owner;
        n_ptr   = ptr;
        n_cnt   = cnt;
        n_fault = fault | (state == ST_IDLE && !bus_n);
        case (state)
            ST_IDLE:  n_state = ST_IDLE;
            ST_GRANT: begin
                n_state = drop ? ST_TURN : ST_GRANT;
                n_gnt   = drop ? '0 : gnt;
                n_cnt   = drop ? 4'(TURN_CYC - 1) : cnt;
            end
            ST_TURN:  begin
                n_cnt   = (cnt != 4'd0) ? cnt - 4'd1 : cnt;
                n_state = (cnt == 4'd0) ? ST_IDLE : ST_TURN;
            end
            default:  begin
                n_state = ST_IDLE;
                n_gnt   = '0;
            end
        endcase
        if (grab) begin
            n_state = ST_GRANT;
            n_gnt   = p_oh;
            n_owner = p_idx;
            n_ptr   = p_idx;
        end
    end

    always_comb oe_n = ~gnt;

`ifdef OCARB_TIMEOUT_EN
    logic [7:0] hcnt;

    assign hold_exp = state == ST_GRANT && req[owner] && hcnt == 8'(HOLD_MAX);

    // hcnt reads 1 on the first grant cycle; a lockout bit clears once its req is seen low.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            hcnt    <= '0;
            lockout <= '0;
            tout    <= 1'b0;
        end else begin
            hcnt    <= grab ? 8'd1 : (state == ST_GRANT) ? hcnt + 8'd1 : hcnt;
            lockout <= (lockout & req) | (hold_exp ? N'(1) << owner : '0);
            tout    <= hold_exp;
        end
    end
`else
    assign hold_exp = 1'b0;
    assign lockout  = '0;
    assign tout     = 1'b0;
`endif

endmodule

// File: tb/tb_oc_bus_arbiter.sv
// tb_oc_bus_arbiter: scoreboard bench for oc_bus_arbiter (TURN_CYC=1 and TURN_CYC=3 instances)
module tb_oc_bus_arbiter;

    typedef struct packed {
        logic [15:0] id;
        logic [3:0]  g;
        logic [1:0]  o;
        logic        f;
        logic        t;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic [3:0] req = 4'b1111, gnt, oe_n;
    logic       bus_n = 1'b1, tout, fault;
    logic [1:0] owner;

    logic [3:0] req3 = 4'b0000, gnt3, oe_n3;
    logic       bus3 = 1'b1, tout3, fault3;
    logic [1:0] owner3;

    exp_t q[$], q3[$];
    exp_t ce, ce3;
    int   n_vec = 0, n_bad = 0;
    logic [15:0] vid = 0;

    always #5 clk = ~clk;

    oc_bus_arbiter #(.N(4), .TURN_CYC(1), .HOLD_MAX(15)) dut (
        .clk(clk), .clr_n(clr_n), .req(req), .bus_n(bus_n),
        .gnt(gnt), .oe_n(oe_n), .owner(owner), .tout(tout), .fault(fault)
    );

    oc_bus_arbiter #(.N(4), .TURN_CYC(3), .HOLD_MAX(15)) dut3 (
        .clk(clk), .clr_n(clr_n), .req(req3), .bus_n(bus3),
        .gnt(gnt3), .oe_n(oe_n3), .owner(owner3), .tout(tout3), .fault(fault3)
    );

    task automatic step(input logic c, input logic [3:0] r, input logic b,
                        input logic [3:0] eg, input logic [1:0] eo, input logic ef, input logic et);
        @(negedge clk);
        #1;
        clr_n = c;
        req   = r;
        bus_n = b;
        q.push_back('{id: vid, g: eg, o: eo, f: ef, t: et});
        vid++;
    endtask

    task automatic step3(input logic [3:0] r, input logic [3:0] eg, input logic [1:0] eo);
        @(negedge clk);
        #1;
        req3 = r;
        q3.push_back('{id: vid, g: eg, o: eo, f: 1'b0, t: 1'b0});
        vid++;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            ce = q.pop_front();
            n_vec++;
            if (gnt !== ce.g || oe_n !== ~ce.g || owner !== ce.o || fault !== ce.f || tout !== ce.t) begin
                n_bad++;
                $display("FAIL vec%0d: got gnt=%b oe_n=%b owner=%0d fault=%b tout=%b, want gnt=%b oe_n=%b owner=%0d fault=%b tout=%b",
                         ce.id, gnt, oe_n, owner, fault, tout, ce.g, ~ce.g, ce.o, ce.f, ce.t);
            end
        end
    end

    always @(negedge clk) begin
        if (q3.size() > 0) begin
            ce3 = q3.pop_front();
            n_vec++;
            if (gnt3 !== ce3.g || oe_n3 !== ~ce3.g || owner3 !== ce3.o || fault3 !== 1'b0 || tout3 !== 1'b0) begin
                n_bad++;
                $display("FAIL turn3 vec%0d: got gnt=%b oe_n=%b owner=%0d fault=%b, want gnt=%b oe_n=%b owner=%0d fault=0",
                         ce3.id, gnt3, oe_n3, owner3, fault3, ce3.g, ~ce3.g, ce3.o);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    // Dead time of three cycles: release at edge k, gnt low on k..k+2, next grant at k+3.
    initial begin
        @(posedge clr_n);
        step3(4'b0011, 4'b0001, 2'd0);
        step3(4'b0011, 4'b0001, 2'd0);
        step3(4'b0010, 4'b0000, 2'd0);
        step3(4'b0011, 4'b0000, 2'd0);
        step3(4'b0011, 4'b0000, 2'd0);
        step3(4'b0011, 4'b0010, 2'd1);
        step3(4'b0001, 4'b0000, 2'd1);
        step3(4'b0001, 4'b0000, 2'd1);
        step3(4'b0001, 4'b0000, 2'd1);
        step3(4'b0001, 4'b0001, 2'd0);
        step3(4'b0000, 4'b0000, 2'd0);
    end

    initial begin
        step(1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        step(1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        step(1'b1, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0);
        step(1'b1, 4'b1110, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        step(1'b1, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b0, 1'b0);
        step(1'b1, 4'b1101, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0);
        step(1'b1, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b0, 1'b0);
        step(1'b1, 4'b1011, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0);
        step(1'b1, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b0, 1'b0);
        step(1'b1, 4'b0111, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0);
        step(1'b1, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0);
        step(1'b1, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0);
        step(1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        step(1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        step(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0);
        step(1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b1, 1'b0);
        step(1'b1, 4'b0101, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0);
        step(1'b1, 4'b0101, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        clr_n = 1'b0;
        #1;
        n_vec++;
        if (gnt !== 4'b0000 || oe_n !== 4'b1111 || owner !== 2'd0 || fault !== 1'b0) begin
            n_bad++;
            $display("FAIL async_clr: got gnt=%b oe_n=%b owner=%0d fault=%b, want gnt=0000 oe_n=1111 owner=0 fault=0",
                     gnt, oe_n, owner, fault);
        end
        step(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        step(1'b1, 4'b0010, 1'b1, 4'b0010, 2'd1, 1'b0, 1'b0);
        step(1'b1, 4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0);
`ifdef OCARB_TIMEOUT_EN
        for (int i = 0; i < 40; i++)
            step(1'b1, 4'b0100, 1'b1, (i < 15) ? 4'b0100 : 4'b0000, 2'd2, 1'b0, i == 15);
        step(1'b1, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0);
        step(1'b1, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b0, 1'b0);
`else
        for (int i = 0; i < 40; i++)
            step(1'b1, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b0, 1'b0);
        step(1'b1, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0);
`endif
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if (q.size() != 0 || q3.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d and %0d expectations left unchecked, want 0 and 0", q.size(), q3.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
